// File: rtl/sram_dp_bank_if.sv
// -----------------------------------------------------------------------------
// sram_dp_bank_if
//   Bundles the write port, read port and clear/busy control of sram_dp_bank.
//   master : the user of the memory (drives requests, receives read data)
//   slave  : the memory bank itself
//
//   clr      master->slave  pulse, start clear sequence
//   busy     slave->master  clear sequence running, requests ignored
//   we       master->slave  write request
//   wr_addr  master->slave  write address
//   wr_data  master->slave  write data
//   wr_be    master->slave  byte enables, bit i covers wr_data[8i+7:8i]
//   re       master->slave  read request
//   rd_addr  master->slave  read address
//   rd_data  slave->master  read data, holds when rd_valid=0
//   rd_valid slave->master  one-cycle pulse marking rd_data valid
// -----------------------------------------------------------------------------
interface sram_dp_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    localparam int BE_W = DATA_W / 8;

    logic              clr;
    logic              busy;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              re;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output clr, we, wr_addr, wr_data, wr_be, re, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clr, we, wr_addr, wr_data, wr_be, re, rd_addr,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/sram_dp_bank.sv
// -----------------------------------------------------------------------------
// sram_dp_bank
//   Simple-dual-port synchronous SRAM bank (one write port, one read port,
//   shared clock) with per-byte write enables, read latency of 1 or 2 cycles,
//   selectable read-during-write behaviour and a clear sequencer that zeroes
//   every word after reset or on a clr pulse.
//
//   Parameters
//     DATA_W    word width, multiple of 8
//     ADDR_W    address width, DEPTH = 2**ADDR_W
//     RD_LAT    read latency, 1 or 2
//     RDW_MODE  same-address read+write: 0 = old data, 1 = new data per byte
//
//   Ports
//     clk  in  single clock, everything on posedge
//     rst  in  synchronous active-high reset
//     bus  slave side of sram_dp_bank_if (write/read ports, clr, busy)
// -----------------------------------------------------------------------------
module sram_dp_bank #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    sram_dp_bank_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Requests are only honoured outside the clear sequence.
    logic wr_acc;
    logic rd_acc;
    assign wr_acc = bus.we & ~busy_q;
    assign rd_acc = bus.re & ~busy_q;

    // -------------------------------------------------------------------------
    // Clear sequencer. cnt_q walks 0..DEPTH-1 once; the last address written
    // hands control back to IDLE, so busy is high for exactly DEPTH cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.clr) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;

    // -------------------------------------------------------------------------
    // Single physical write port shared by the clear sequencer and the user.
    // -------------------------------------------------------------------------
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; that is what keeps this block from becoming a latch.
    always_comb begin
        mem_we    = wr_acc;
        mem_addr  = bus.wr_addr;
        mem_wdata = bus.wr_data;
        mem_be    = bus.wr_be;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end
    end

    // NOTE: the array deliberately has no reset branch so it maps onto RAM
    // macros; its contents are zeroed by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read word. The array update is non-blocking, so a plain array read in
    // the same cycle as a write sees the old word (read-first). Write-through
    // mode patches the enabled bytes from the write port.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] rd_word;

    // NOTE: combinational logic uses blocking '=' so later statements see the
    // patched bytes; registers below use '<=' so all flops update together.
    always_comb begin
        rd_word = mem_q[bus.rd_addr];
        if (RDW_MODE == 1 && wr_acc && (bus.wr_addr == bus.rd_addr)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.wr_be[i]) begin
                    rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline. Reads accepted before a clr keep flowing to the output
    // even though the bank has gone busy.
    // -------------------------------------------------------------------------
    logic              rd_valid_d;
    logic [DATA_W-1:0] rd_data_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_valid_q;
            logic [DATA_W-1:0] s1_data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                end else begin
                    s1_valid_q <= rd_acc;
                    if (rd_acc) begin
                        s1_data_q <= rd_word;
                    end
                end
            end

            assign rd_valid_d = s1_valid_q;
            assign rd_data_d  = s1_data_q;
        end else begin : g_lat1
            assign rd_valid_d = rd_acc;
            assign rd_data_d  = rd_word;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            if (rd_valid_d) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule
